// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for the single data-memory port: round-robin grant per transaction,
// registered memory-side request, and a BUSY watchdog that aborts hung accesses.
module mem_port_arbiter #(
  parameter int AW      = 64,
  parameter int DW      = 64,
  parameter int MW      = 8,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] m0_address,
  input  logic          m0_ren,
  input  logic          m0_wen,
  input  logic [DW-1:0] m0_wdata,
  input  logic [MW-1:0] m0_wmask,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_valid,
  output logic          m0_err,
  input  logic [AW-1:0] m1_address,
  input  logic          m1_ren,
  input  logic          m1_wen,
  input  logic [DW-1:0] m1_wdata,
  input  logic [MW-1:0] m1_wmask,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_valid,
  output logic          m1_err,
  output logic [AW-1:0] address_mem,
  output logic          ren_mem,
  output logic          wen_mem,
  output logic [MW-1:0] wmask_mem,
  output logic [DW-1:0] wdata_mem,
  input  logic [DW-1:0] rdata_mem,
  input  logic          valid_mem
);

  localparam int              WD_W     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = (TIMEOUT == 0) ? '0 : WD_W'(TIMEOUT - 1);
  localparam bit              WD_EN    = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic            rr_ptr, rr_ptr_nxt;
  logic [WD_W-1:0] wd_cnt;
  logic            req0, req1;
  logic            grant0, grant1;
  logic            finish;
  logic            wd_hit;

  assign req0   = m0_ren | m0_wen;
  assign req1   = m1_ren | m1_wen;
  assign wd_hit = WD_EN && (wd_cnt == WD_LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      rr_ptr <= 1'b0;
    end else begin
      state  <= state_nxt;
      rr_ptr <= rr_ptr_nxt;
    end
  end

  // rr_ptr names the master preferred when both request in the same IDLE cycle.
  always_comb begin
    state_nxt  = state;
    rr_ptr_nxt = rr_ptr;
    grant0     = 1'b0;
    grant1     = 1'b0;
    finish     = 1'b0;
    m0_valid   = 1'b0;
    m1_valid   = 1'b0;
    m0_err     = 1'b0;
    m1_err     = 1'b0;
    case (state)
      IDLE: begin
        if (req0 && (!req1 || !rr_ptr)) begin
          grant0    = 1'b1;
          state_nxt = BUSY0;
        end else if (req1) begin
          grant1    = 1'b1;
          state_nxt = BUSY1;
        end
      end
      BUSY0: begin
        if (valid_mem) begin
          m0_valid = 1'b1;
          finish   = 1'b1;
        end else if (wd_hit) begin
          m0_err = 1'b1;
          finish = 1'b1;
        end
        if (finish) begin
          state_nxt  = IDLE;
          rr_ptr_nxt = 1'b1;
        end
      end
      BUSY1: begin
        if (valid_mem) begin
          m1_valid = 1'b1;
          finish   = 1'b1;
        end else if (wd_hit) begin
          m1_err = 1'b1;
          finish = 1'b1;
        end
        if (finish) begin
          state_nxt  = IDLE;
          rr_ptr_nxt = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign m0_rdata = m0_valid ? rdata_mem : '0;
  assign m1_rdata = m1_valid ? rdata_mem : '0;

  // Write wins when a master raises both enables.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      address_mem <= '0;
      ren_mem     <= 1'b0;
      wen_mem     <= 1'b0;
      wmask_mem   <= '0;
      wdata_mem   <= '0;
    end else if (grant0) begin
      address_mem <= m0_address;
      ren_mem     <= m0_ren & ~m0_wen;
      wen_mem     <= m0_wen;
      wmask_mem   <= m0_wmask;
      wdata_mem   <= m0_wdata;
    end else if (grant1) begin
      address_mem <= m1_address;
      ren_mem     <= m1_ren & ~m1_wen;
      wen_mem     <= m1_wen;
      wmask_mem   <= m1_wmask;
      wdata_mem   <= m1_wdata;
    end else if (finish) begin
      ren_mem   <= 1'b0;
      wen_mem   <= 1'b0;
      wmask_mem <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt <= '0;
    end else if (grant0 || grant1) begin
      wd_cnt <= '0;
    end else if ((state != IDLE) && (wd_cnt != '1)) begin
      wd_cnt <= wd_cnt + WD_W'(1);
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized transaction stream
// checked against a transaction-level round-robin/watchdog model.
module tb_mem_port_arbiter;

  localparam int AW      = 64;
  localparam int DW      = 64;
  localparam int MW      = 8;
  localparam int TIMEOUT = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] m0_address, m1_address, address_mem;
  logic          m0_ren, m0_wen, m1_ren, m1_wen;
  logic [DW-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, wdata_mem, rdata_mem;
  logic [MW-1:0] m0_wmask, m1_wmask, wmask_mem;
  logic          m0_valid, m0_err, m1_valid, m1_err;
  logic          ren_mem, wen_mem, valid_mem;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model state for the random stream: pending request per master and the preferred master.
  logic          p_act   [2];
  logic [AW-1:0] p_addr  [2];
  logic          p_ren   [2];
  logic          p_wen   [2];
  logic [DW-1:0] p_wdata [2];
  logic [MW-1:0] p_wmask [2];
  int            pref;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MW(MW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .m0_address(m0_address), .m0_ren(m0_ren), .m0_wen(m0_wen), .m0_wdata(m0_wdata),
    .m0_wmask(m0_wmask), .m0_rdata(m0_rdata), .m0_valid(m0_valid), .m0_err(m0_err),
    .m1_address(m1_address), .m1_ren(m1_ren), .m1_wen(m1_wen), .m1_wdata(m1_wdata),
    .m1_wmask(m1_wmask), .m1_rdata(m1_rdata), .m1_valid(m1_valid), .m1_err(m1_err),
    .address_mem(address_mem), .ren_mem(ren_mem), .wen_mem(wen_mem), .wmask_mem(wmask_mem),
    .wdata_mem(wdata_mem), .rdata_mem(rdata_mem), .valid_mem(valid_mem)
  );

  always #5 clk = ~clk;

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    m0_address = '0; m0_ren = 0; m0_wen = 0; m0_wdata = '0; m0_wmask = '0;
    m1_address = '0; m1_ren = 0; m1_wen = 0; m1_wdata = '0; m1_wmask = '0;
    rdata_mem = '0; valid_mem = 0;
  endtask

  task automatic apply_reset();
    nxt();
    rst = 1;
    clear_inputs();
    nxt();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    clear_inputs();
    valid_mem = 1;
    rdata_mem = 64'hFFFF_0000_1234_5678;
    repeat (2) @(posedge clk);
    smp();
    n_cmp++;
    if ({address_mem, ren_mem, wen_mem, wmask_mem, wdata_mem} !== '0) begin
      n_fail++; $display("FAIL reset_mem_out: got addr=%h ren=%b wen=%b required all 0", address_mem, ren_mem, wen_mem);
    end
    n_cmp++;
    if ({m0_valid, m0_err, m1_valid, m1_err} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_pulses: got %b required 0000", {m0_valid, m0_err, m1_valid, m1_err});
    end
    n_cmp++;
    if ({m0_rdata, m1_rdata} !== '0) begin
      n_fail++; $display("FAIL reset_rdata: got %h/%h required 0", m0_rdata, m1_rdata);
    end
    nxt();
    rst = 0;
    clear_inputs();
    smp();
    n_cmp++;
    if ({ren_mem, wen_mem, m0_valid, m1_valid} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_release: got %b required 0000", {ren_mem, wen_mem, m0_valid, m1_valid});
    end
  endtask

  task automatic test_single_read();
    nxt();
    m0_address = 64'h1000;
    m0_ren = 1;
    smp();
    n_cmp++;
    if (ren_mem !== 1'b0) begin
      n_fail++; $display("FAIL rd_ren_early: got %b required 0", ren_mem);
    end
    for (int k = 1; k <= 3; k++) begin
      nxt();
      valid_mem = (k == 3);
      rdata_mem = (k == 3) ? 64'hDEAD : 64'h0BAD;
      smp();
      n_cmp++;
      if ({ren_mem, address_mem} !== {1'b1, 64'h1000}) begin
        n_fail++; $display("FAIL rd_mem_req c%0d: got ren=%b addr=%h required 1/1000", k, ren_mem, address_mem);
      end
      n_cmp++;
      if ({m0_valid, m0_err, m1_valid, m1_err} !== ((k == 3) ? 4'b1000 : 4'b0000)) begin
        n_fail++; $display("FAIL rd_pulses c%0d: got %b", k, {m0_valid, m0_err, m1_valid, m1_err});
      end
    end
    n_cmp++;
    if (m0_rdata !== 64'hDEAD) begin
      n_fail++; $display("FAIL rd_rdata: got %h required dead", m0_rdata);
    end
    nxt();
    m0_ren = 0;
    valid_mem = 0;
    rdata_mem = 64'h1234;
    smp();
    n_cmp++;
    if ({ren_mem, m0_valid, m0_rdata, address_mem} !== {1'b0, 1'b0, 64'h0, 64'h1000}) begin
      n_fail++; $display("FAIL rd_after: got ren=%b v=%b rdata=%h addr=%h required 0/0/0/1000", ren_mem, m0_valid, m0_rdata, address_mem);
    end
    clear_inputs();
  endtask

  task automatic test_rr_alternate();
    logic [3:0] exp_p;
    apply_reset();
    m0_ren = 1; m0_address = 64'hA000;
    m1_ren = 1; m1_address = 64'hB000;
    smp();
    for (int i = 0; i < 4; i++) begin
      nxt();
      valid_mem = 1;
      rdata_mem = 64'(i + 100);
      smp();
      exp_p = (i % 2 == 0) ? 4'b1000 : 4'b0010;
      n_cmp++;
      if (address_mem !== ((i % 2 == 0) ? 64'hA000 : 64'hB000)) begin
        n_fail++; $display("FAIL rr_grant %0d: got addr=%h", i, address_mem);
      end
      n_cmp++;
      if ({m0_valid, m0_err, m1_valid, m1_err} !== exp_p) begin
        n_fail++; $display("FAIL rr_pulses %0d: got %b required %b", i, {m0_valid, m0_err, m1_valid, m1_err}, exp_p);
      end
      nxt();
      valid_mem = 0;
      if (i == 3) clear_inputs();
      smp();
      n_cmp++;
      if ({ren_mem, m0_valid, m1_valid} !== 3'b000) begin
        n_fail++; $display("FAIL rr_idle %0d: got %b required 000", i, {ren_mem, m0_valid, m1_valid});
      end
    end
  endtask

  task automatic test_wait_write();
    nxt();
    m0_ren = 1; m0_address = 64'h3000;
    smp();
    for (int k = 1; k <= 3; k++) begin
      nxt();
      if (k == 1) begin
        m1_wen = 1; m1_address = 64'h2008; m1_wdata = 64'h55; m1_wmask = 8'h0F;
      end
      valid_mem = (k == 3);
      smp();
      n_cmp++;
      if ({wen_mem, address_mem, m1_valid, m0_valid} !== {1'b0, 64'h3000, 1'b0, (k == 3)}) begin
        n_fail++; $display("FAIL ww_busy0 c%0d: got wen=%b addr=%h v1=%b v0=%b", k, wen_mem, address_mem, m1_valid, m0_valid);
      end
    end
    nxt();
    m0_ren = 0;
    valid_mem = 0;
    smp();
    n_cmp++;
    if ({wen_mem, ren_mem, wmask_mem} !== '0) begin
      n_fail++; $display("FAIL ww_idle: got wen=%b ren=%b mask=%h required 0", wen_mem, ren_mem, wmask_mem);
    end
    nxt();
    smp();
    n_cmp++;
    if ({wen_mem, ren_mem, wdata_mem, wmask_mem, address_mem} !== {1'b1, 1'b0, 64'h55, 8'h0F, 64'h2008}) begin
      n_fail++; $display("FAIL ww_grant: got wen=%b ren=%b data=%h mask=%h addr=%h required 1/0/55/0f/2008", wen_mem, ren_mem, wdata_mem, wmask_mem, address_mem);
    end
    nxt();
    valid_mem = 1;
    smp();
    n_cmp++;
    if ({m0_valid, m0_err, m1_valid, m1_err} !== 4'b0010) begin
      n_fail++; $display("FAIL ww_done: got %b required 0010", {m0_valid, m0_err, m1_valid, m1_err});
    end
    nxt();
    clear_inputs();
    smp();
  endtask

  task automatic test_timeout();
    nxt();
    m0_ren = 1; m0_address = 64'h4000;
    smp();
    for (int k = 1; k <= TIMEOUT; k++) begin
      nxt();
      if (k == 1) begin
        m1_ren = 1; m1_address = 64'h5000;
      end
      smp();
      n_cmp++;
      if ({m0_valid, m0_err, m1_valid, m1_err, ren_mem} !== {1'b0, (k == TIMEOUT), 2'b00, 1'b1}) begin
        n_fail++; $display("FAIL to_abort c%0d: got %b required %b", k, {m0_valid, m0_err, m1_valid, m1_err, ren_mem}, {1'b0, (k == TIMEOUT), 2'b00, 1'b1});
      end
    end
    nxt();
    m0_ren = 0;
    smp();
    n_cmp++;
    if ({ren_mem, m0_err, m0_valid} !== 3'b000) begin
      n_fail++; $display("FAIL to_idle: got %b required 000", {ren_mem, m0_err, m0_valid});
    end
    nxt();
    smp();
    n_cmp++;
    if ({ren_mem, address_mem} !== {1'b1, 64'h5000}) begin
      n_fail++; $display("FAIL to_m1_grant: got ren=%b addr=%h required 1/5000", ren_mem, address_mem);
    end
    nxt();
    valid_mem = 1;
    smp();
    n_cmp++;
    if ({m0_valid, m0_err, m1_valid, m1_err} !== 4'b0010) begin
      n_fail++; $display("FAIL to_m1_done: got %b required 0010", {m0_valid, m0_err, m1_valid, m1_err});
    end
    nxt();
    clear_inputs();
    smp();
    nxt();
    m0_ren = 1; m0_address = 64'h6000;
    smp();
    for (int k = 1; k <= TIMEOUT; k++) begin
      nxt();
      valid_mem = (k == TIMEOUT);
      rdata_mem = 64'hBEEF;
      smp();
      n_cmp++;
      if ({m0_valid, m0_err, m1_valid, m1_err} !== {(k == TIMEOUT), 3'b000}) begin
        n_fail++; $display("FAIL to_late_valid c%0d: got %b", k, {m0_valid, m0_err, m1_valid, m1_err});
      end
    end
    nxt();
    clear_inputs();
    smp();
    n_cmp++;
    if ({ren_mem, m0_err} !== 2'b00) begin
      n_fail++; $display("FAIL to_late_after: got %b required 00", {ren_mem, m0_err});
    end
  endtask

  task automatic test_ren_wen();
    logic [DW-1:0] d;
    d = {$urandom, $urandom};
    nxt();
    m1_ren = 1; m1_wen = 1; m1_address = 64'h7000; m1_wdata = d; m1_wmask = 8'hFF;
    smp();
    nxt();
    smp();
    n_cmp++;
    if ({wen_mem, ren_mem, wdata_mem} !== {1'b1, 1'b0, d}) begin
      n_fail++; $display("FAIL rw_both: got wen=%b ren=%b data=%h required 1/0/%h", wen_mem, ren_mem, wdata_mem, d);
    end
    nxt();
    valid_mem = 1;
    smp();
    n_cmp++;
    if (m1_valid !== 1'b1) begin
      n_fail++; $display("FAIL rw_done: got %b required 1", m1_valid);
    end
    nxt();
    clear_inputs();
    smp();
  endtask

  task automatic test_reset_mid();
    nxt();
    m0_ren = 1; m0_address = 64'h8000;
    smp();
    nxt();
    valid_mem = 1;
    smp();
    nxt();
    clear_inputs();
    m1_wen = 1; m1_address = 64'h9000; m1_wdata = 64'h77; m1_wmask = 8'h03;
    smp();
    nxt();
    smp();
    n_cmp++;
    if ({wen_mem, address_mem} !== {1'b1, 64'h9000}) begin
      n_fail++; $display("FAIL rm_busy1: got wen=%b addr=%h required 1/9000", wen_mem, address_mem);
    end
    nxt();
    rst = 1;
    clear_inputs();
    smp();
    n_cmp++;
    if ({address_mem, ren_mem, wen_mem, wmask_mem, wdata_mem} !== '0) begin
      n_fail++; $display("FAIL rm_in_reset: got addr=%h wen=%b data=%h required 0", address_mem, wen_mem, wdata_mem);
    end
    nxt();
    rst = 0;
    valid_mem = 1;
    rdata_mem = 64'h1111;
    smp();
    n_cmp++;
    if ({m0_valid, m0_err, m1_valid, m1_err, ren_mem, wen_mem} !== 6'b0) begin
      n_fail++; $display("FAIL rm_stray: got %b required 000000", {m0_valid, m0_err, m1_valid, m1_err, ren_mem, wen_mem});
    end
    n_cmp++;
    if ({m0_rdata, m1_rdata} !== '0) begin
      n_fail++; $display("FAIL rm_stray_rdata: got %h/%h required 0", m0_rdata, m1_rdata);
    end
    nxt();
    valid_mem = 0;
    m0_ren = 1; m0_address = 64'hC000;
    m1_ren = 1; m1_address = 64'hD000;
    smp();
    nxt();
    smp();
    n_cmp++;
    if (address_mem !== 64'hC000) begin
      n_fail++; $display("FAIL rm_rr_ptr: got addr=%h required c000", address_mem);
    end
    nxt();
    valid_mem = 1;
    smp();
    nxt();
    clear_inputs();
    smp();
  endtask

  task automatic gen_req(input int m);
    int kind;
    kind       = $urandom_range(0, 2);
    p_act[m]   = 1;
    p_addr[m]  = {$urandom, $urandom};
    p_ren[m]   = (kind != 1);
    p_wen[m]   = (kind != 0);
    p_wdata[m] = {$urandom, $urandom};
    p_wmask[m] = 8'($urandom);
  endtask

  task automatic drive_masters();
    m0_address = p_addr[0]; m0_ren = p_act[0] & p_ren[0]; m0_wen = p_act[0] & p_wen[0];
    m0_wdata = p_wdata[0]; m0_wmask = p_wmask[0];
    m1_address = p_addr[1]; m1_ren = p_act[1] & p_ren[1]; m1_wen = p_act[1] & p_wen[1];
    m1_wdata = p_wdata[1]; m1_wmask = p_wmask[1];
  endtask

  task automatic test_random();
    int            w, lat;
    logic          done_v, exp_err;
    logic [DW-1:0] rd;
    logic [3:0]    exp_p;
    apply_reset();
    pref = 0;
    for (int m = 0; m < 2; m++) begin
      p_act[m] = 0; p_addr[m] = '0; p_ren[m] = 0; p_wen[m] = 0; p_wdata[m] = '0; p_wmask[m] = '0;
    end
    for (int t = 0; t < 40; t++) begin
      nxt();
      for (int m = 0; m < 2; m++)
        if (!p_act[m] && ($urandom_range(0, 1) == 1)) gen_req(m);
      if (!p_act[0] && !p_act[1]) gen_req($urandom_range(0, 1));
      drive_masters();
      valid_mem = 1'($urandom_range(0, 1));
      rdata_mem = {$urandom, $urandom};
      smp();
      n_cmp++;
      if ({m0_valid, m0_err, m1_valid, m1_err, ren_mem, wen_mem} !== 6'b0) begin
        n_fail++; $display("FAIL rnd_idle t%0d: got %b required 000000", t, {m0_valid, m0_err, m1_valid, m1_err, ren_mem, wen_mem});
      end
      w = (p_act[0] && p_act[1]) ? pref : (p_act[0] ? 0 : 1);
      lat = $urandom_range(1, TIMEOUT + 2);
      for (int k = 1; k <= TIMEOUT; k++) begin
        nxt();
        if (k == 2 && !p_act[1 - w] && ($urandom_range(0, 1) == 1)) begin
          gen_req(1 - w);
          drive_masters();
        end
        rd = {$urandom, $urandom};
        valid_mem = (k == lat);
        rdata_mem = rd;
        smp();
        done_v  = (k == lat);
        exp_err = (k == TIMEOUT) && (lat > TIMEOUT);
        n_cmp++;
        if ({address_mem, ren_mem, wen_mem, wdata_mem, wmask_mem} !==
            {p_addr[w], p_ren[w] & ~p_wen[w], p_wen[w], p_wdata[w], p_wmask[w]}) begin
          n_fail++; $display("FAIL rnd_mem t%0d c%0d m%0d: got addr=%h ren=%b wen=%b required addr=%h ren=%b wen=%b",
                             t, k, w, address_mem, ren_mem, wen_mem, p_addr[w], p_ren[w] & ~p_wen[w], p_wen[w]);
        end
        exp_p = (w == 0) ? {done_v, exp_err, 2'b00} : {2'b00, done_v, exp_err};
        n_cmp++;
        if ({m0_valid, m0_err, m1_valid, m1_err} !== exp_p) begin
          n_fail++; $display("FAIL rnd_pulses t%0d c%0d: got %b required %b", t, k, {m0_valid, m0_err, m1_valid, m1_err}, exp_p);
        end
        n_cmp++;
        if ({m0_rdata, m1_rdata} !== ((w == 0) ? {(done_v ? rd : 64'h0), 64'h0} : {64'h0, (done_v ? rd : 64'h0)})) begin
          n_fail++; $display("FAIL rnd_rdata t%0d c%0d: got %h/%h", t, k, m0_rdata, m1_rdata);
        end
        if (done_v || exp_err) break;
      end
      p_act[w] = 0;
      pref = 1 - w;
    end
    nxt();
    for (int m = 0; m < 2; m++) p_act[m] = 0;
    clear_inputs();
    smp();
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    test_reset();
    test_single_read();
    test_rr_alternate();
    test_wait_write();
    test_timeout();
    test_ren_wen();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
